spi_rx_slave: RTL and testbench

- SPI slave receive stage, directly downstream of the team's system-clock SPI master. Consumes its cs/sclk/mosi and produces parallel bytes for on-chip logic.
- Oversamples all three SPI lines with the local system clock (no SPI-clock domain).
- Shifts in MSB first and presents each completed byte through a one-entry valid/ready output register.
- Flags overrun and aborted frames.

---
 rtl/spi_rx_slave_if.sv | 28 ++
 rtl/spi_rx_slave.sv | 159 +++++++++++++++
 tb/tb_spi_rx_slave.sv | 368 ++++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/spi_rx_slave_if.sv
// Bundle of the SPI receive-stage signals between spi_rx_slave and its neighbours.
//   master modport: drives cs/sclk/mosi, rx_ready and clr_err; observes the received word and status
//   slave  modport: the receive stage itself (spi_rx_slave)
interface spi_rx_slave_if #(
    parameter int unsigned DATA_W = 8
);
    logic              cs;
    logic              sclk;
    logic              mosi;
    logic              rx_ready;
    logic              clr_err;
    logic [DATA_W-1:0] rx_data;
    logic              rx_valid;
    logic              busy;
    logic [7:0]        byte_cnt;
    logic              overrun;
    logic              frame_err;

    modport master (
        output cs, sclk, mosi, rx_ready, clr_err,
        input  rx_data, rx_valid, busy, byte_cnt, overrun, frame_err
    );

    modport slave (
        input  cs, sclk, mosi, rx_ready, clr_err,
        output rx_data, rx_valid, busy, byte_cnt, overrun, frame_err
    );
endinterface

// File: rtl/spi_rx_slave.sv
// SPI slave receive stage. Oversamples cs/sclk/mosi with clk, shifts words in MSB first
// and presents each completed word through a one-entry valid/ready output register.
//   clk  : system clock, rising edge
//   rst  : asynchronous active-low reset
//   bus  : spi_rx_slave_if.slave -- cs/sclk/mosi in, rx_ready/clr_err in,
//          rx_data/rx_valid/busy/byte_cnt/overrun/frame_err out (all registered)
module spi_rx_slave #(
    parameter int unsigned DATA_W      = 8,
    parameter bit          SAMPLE_RISE = 1'b1
) (
    input logic           clk,
    input logic           rst,
    spi_rx_slave_if.slave bus
);
    localparam int unsigned CNT_W = $clog2(DATA_W);
    localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(DATA_W - 1);

    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_SHIFT = 1'b1
    } state_t;

    state_t state, state_n;

    logic cs_s1, cs_s2, cs_s3;
    logic sclk_s1, sclk_s2, sclk_s3;
    logic mosi_s1, mosi_s2;

    logic [DATA_W-2:0] shift_q, shift_n;
    logic [CNT_W-1:0]  bit_q, bit_n;
    logic [7:0]        byte_q, byte_n;
    logic [DATA_W-1:0] data_q, data_n;
    logic              valid_q, valid_n;
    logic              ovr_q, ovr_n;
    logic              ferr_q, ferr_n;
    logic              busy_q;

    logic              cs_fall, cs_rise, sample_edge;
    logic [DATA_W-1:0] word;

    // Two-flop synchronizers, plus a third stage on cs/sclk for edge detection.
    // Idle levels at reset: cs high, sclk high, mosi low.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cs_s1   <= 1'b1;
            cs_s2   <= 1'b1;
            cs_s3   <= 1'b1;
            sclk_s1 <= 1'b1;
            sclk_s2 <= 1'b1;
            sclk_s3 <= 1'b1;
            mosi_s1 <= 1'b0;
            mosi_s2 <= 1'b0;
        end else begin
            cs_s1   <= bus.cs;
            cs_s2   <= cs_s1;
            cs_s3   <= cs_s2;
            sclk_s1 <= bus.sclk;
            sclk_s2 <= sclk_s1;
            sclk_s3 <= sclk_s2;
            mosi_s1 <= bus.mosi;
            mosi_s2 <= mosi_s1;
        end
    end

    assign cs_fall     = ~cs_s2 & cs_s3;
    assign cs_rise     = cs_s2 & ~cs_s3;
    assign sample_edge = SAMPLE_RISE ? (sclk_s2 & ~sclk_s3) : (~sclk_s2 & sclk_s3);
    assign word        = {shift_q, mosi_s2};

    // State and datapath registers.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state   <= ST_IDLE;
            shift_q <= '0;
            bit_q   <= '0;
            byte_q  <= '0;
            data_q  <= '0;
            valid_q <= 1'b0;
            ovr_q   <= 1'b0;
            ferr_q  <= 1'b0;
            busy_q  <= 1'b0;
        end else begin
            state   <= state_n;
            shift_q <= shift_n;
            bit_q   <= bit_n;
            byte_q  <= byte_n;
            data_q  <= data_n;
            valid_q <= valid_n;
            ovr_q   <= ovr_n;
            ferr_q  <= ferr_n;
            busy_q  <= (state_n == ST_SHIFT);
        end
    end

    // Next-state and datapath update. Error clears are applied before set events so a set wins.
    always_comb begin
        state_n = state;
        shift_n = shift_q;
        bit_n   = bit_q;
        byte_n  = byte_q;
        data_n  = data_q;
        valid_n = valid_q;
        ovr_n   = ovr_q;
        ferr_n  = ferr_q;

        if (valid_q && bus.rx_ready) begin
            valid_n = 1'b0;
        end
        if (bus.clr_err) begin
            ovr_n  = 1'b0;
            ferr_n = 1'b0;
        end

        case (state)
            ST_IDLE: begin
                if (cs_fall) begin
                    bit_n   = '0;
                    byte_n  = '0;
                    state_n = ST_SHIFT;
                end
            end
            ST_SHIFT: begin
                // cs deassertion takes priority over a coincident sample edge
                if (cs_rise) begin
                    if (bit_q != '0) begin
                        ferr_n = 1'b1;
                    end
                    bit_n   = '0;
                    state_n = ST_IDLE;
                end else if (sample_edge) begin
                    shift_n = word[DATA_W-2:0];
                    if (bit_q == LAST_BIT) begin
                        bit_n = '0;
                        // Load when empty or when the held word is consumed this cycle; else drop.
                        if (!valid_q || bus.rx_ready) begin
                            data_n  = word;
                            valid_n = 1'b1;
                        end else begin
                            ovr_n = 1'b1;
                        end
                        if (byte_q != 8'hFF) begin
                            byte_n = byte_q + 8'd1;
                        end
                    end else begin
                        bit_n = bit_q + CNT_W'(1);
                    end
                end
            end
            default: state_n = ST_IDLE;
        endcase
    end

    assign bus.rx_data   = data_q;
    assign bus.rx_valid  = valid_q;
    assign bus.busy      = busy_q;
    assign bus.byte_cnt  = byte_q;
    assign bus.overrun   = ovr_q;
    assign bus.frame_err = ferr_q;
endmodule

// File: tb/tb_spi_rx_slave.sv
// Bench for spi_rx_slave: one rising-sample instance (a) and one falling-sample instance (b),
// driven as an SPI master from the clk falling edge, checked against a word-level model.
module tb_spi_rx_slave;
    localparam int unsigned DATA_W = 8;
    localparam int unsigned HALF   = 4;

    logic clk;
    logic rst;

    int nvec;
    int nerr;

    logic [7:0] xfers[$];
    logic [7:0] exp_q[$];

    spi_rx_slave_if #(.DATA_W(DATA_W)) bus_a ();
    spi_rx_slave_if #(.DATA_W(DATA_W)) bus_b ();

    spi_rx_slave #(.DATA_W(DATA_W), .SAMPLE_RISE(1'b1)) dut_a (
        .clk (clk),
        .rst (rst),
        .bus (bus_a)
    );

    spi_rx_slave #(.DATA_W(DATA_W), .SAMPLE_RISE(1'b0)) dut_b (
        .clk (clk),
        .rst (rst),
        .bus (bus_b)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Record every handshake transfer on instance a
    always @(posedge clk) begin
        if (rst && bus_a.rx_valid && bus_a.rx_ready) begin
            xfers.push_back(bus_a.rx_data);
        end
    end

    task automatic wait_neg(input int n);
        repeat (n) @(negedge clk);
    endtask

    // Send the top n bits of v, MSB first; mosi changes while sclk low, sampled on rise
    task automatic spi_bits(input logic [7:0] v, input int n);
        for (int i = 0; i < n; i++) begin
            bus_a.mosi = v[7-i];
            wait_neg(HALF);
            bus_a.sclk = 1'b1;
            wait_neg(HALF);
            bus_a.sclk = 1'b0;
        end
    endtask

    task automatic cs_start();
        bus_a.cs = 1'b0;
        wait_neg(HALF);
    endtask

    task automatic cs_end();
        wait_neg(HALF);
        bus_a.cs = 1'b1;
        wait_neg(6);
    endtask

    task automatic drain_a();
        bus_a.rx_ready = 1'b1;
        wait_neg(2);
        bus_a.rx_ready = 1'b0;
        xfers.delete();
    endtask

    task automatic pulse_clr_a();
        bus_a.clr_err = 1'b1;
        wait_neg(1);
        bus_a.clr_err = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b0;
        for (int i = 0; i < 6; i++) begin
            bus_a.sclk = ~bus_a.sclk;
            bus_a.cs   = i[0];
            wait_neg(1);
        end
        bus_a.cs   = 1'b1;
        bus_a.sclk = 1'b0;
        wait_neg(1);
        nvec++;
        if ({bus_a.rx_data, bus_a.rx_valid, bus_a.busy, bus_a.byte_cnt, bus_a.overrun, bus_a.frame_err} !== 21'd0) begin
            nerr++;
            $display("FAIL reset_outputs got data=%h v=%b busy=%b cnt=%0d ovr=%b ferr=%b want all 0",
                     bus_a.rx_data, bus_a.rx_valid, bus_a.busy, bus_a.byte_cnt, bus_a.overrun, bus_a.frame_err);
        end
        rst = 1'b1;
        wait_neg(4);
        cs_start();
        spi_bits(8'hFE, 7);
        bus_a.mosi = 1'b0;
        wait_neg(HALF);
        bus_a.sclk = 1'b1;
        @(posedge clk);
        @(posedge clk);
        #1;
        nvec++;
        if (bus_a.rx_valid !== 1'b0) begin
            nerr++;
            $display("FAIL latency_early got rx_valid=%b want 0 two edges after last sclk", bus_a.rx_valid);
        end
        @(posedge clk);
        #1;
        nvec++;
        if (bus_a.rx_valid !== 1'b1 || bus_a.rx_data !== 8'hFE) begin
            nerr++;
            $display("FAIL latency_third got v=%b data=%h want v=1 data=fe", bus_a.rx_valid, bus_a.rx_data);
        end
        wait_neg(HALF);
        bus_a.sclk = 1'b0;
        cs_end();
        nvec++;
        if (bus_a.byte_cnt !== 8'd1 || bus_a.rx_data !== 8'hFE) begin
            nerr++;
            $display("FAIL reset_first_word got cnt=%0d data=%h want 1 fe", bus_a.byte_cnt, bus_a.rx_data);
        end
    endtask

    task automatic test_back_to_back();
        drain_a();
        bus_a.rx_ready = 1'b1;
        exp_q = '{8'hA5, 8'h3C};
        cs_start();
        spi_bits(8'hA5, 8);
        spi_bits(8'h3C, 8);
        wait_neg(HALF);
        bus_a.cs = 1'b1;
        @(posedge clk);
        @(posedge clk);
        #1;
        nvec++;
        if (bus_a.busy !== 1'b1) begin
            nerr++;
            $display("FAIL busy_hold got busy=%b want 1 two edges after cs rise", bus_a.busy);
        end
        @(posedge clk);
        #1;
        nvec++;
        if (bus_a.busy !== 1'b0) begin
            nerr++;
            $display("FAIL busy_fall got busy=%b want 0 three edges after cs rise", bus_a.busy);
        end
        wait_neg(4);
        nvec++;
        if (xfers.size() != exp_q.size() || xfers != exp_q) begin
            nerr++;
            $display("FAIL b2b_order got %0d xfers first=%h want 2 xfers a5,3c",
                     xfers.size(), (xfers.size() > 0) ? xfers[0] : 8'hxx);
        end
        nvec++;
        if (bus_a.byte_cnt !== 8'd2 || bus_a.overrun !== 1'b0 || bus_a.rx_valid !== 1'b0) begin
            nerr++;
            $display("FAIL b2b_status got cnt=%0d ovr=%b v=%b want 2 0 0",
                     bus_a.byte_cnt, bus_a.overrun, bus_a.rx_valid);
        end
        bus_a.rx_ready = 1'b0;
    endtask

    task automatic test_overrun();
        cs_start();
        spi_bits(8'h11, 8);
        spi_bits(8'h22, 8);
        cs_end();
        nvec++;
        if (bus_a.rx_data !== 8'h11 || bus_a.overrun !== 1'b1 || bus_a.byte_cnt !== 8'd2 || bus_a.rx_valid !== 1'b1) begin
            nerr++;
            $display("FAIL overrun_set got data=%h ovr=%b cnt=%0d v=%b want 11 1 2 1",
                     bus_a.rx_data, bus_a.overrun, bus_a.byte_cnt, bus_a.rx_valid);
        end
        pulse_clr_a();
        nvec++;
        if (bus_a.overrun !== 1'b0 || bus_a.rx_valid !== 1'b1 || bus_a.rx_data !== 8'h11) begin
            nerr++;
            $display("FAIL overrun_clear got ovr=%b v=%b data=%h want 0 1 11",
                     bus_a.overrun, bus_a.rx_valid, bus_a.rx_data);
        end
    endtask

    task automatic test_abort();
        cs_start();
        spi_bits(8'hFF, 5);
        cs_end();
        nvec++;
        if (bus_a.frame_err !== 1'b1 || bus_a.rx_valid !== 1'b1 || bus_a.rx_data !== 8'h11
            || bus_a.byte_cnt !== 8'd0 || bus_a.busy !== 1'b0) begin
            nerr++;
            $display("FAIL abort_flag got ferr=%b v=%b data=%h cnt=%0d busy=%b want 1 1 11 0 0",
                     bus_a.frame_err, bus_a.rx_valid, bus_a.rx_data, bus_a.byte_cnt, bus_a.busy);
        end
        pulse_clr_a();
        nvec++;
        if (bus_a.frame_err !== 1'b0) begin
            nerr++;
            $display("FAIL abort_clear got ferr=%b want 0", bus_a.frame_err);
        end
        drain_a();
        cs_start();
        spi_bits(8'h5A, 8);
        cs_end();
        nvec++;
        if (bus_a.rx_data !== 8'h5A || bus_a.rx_valid !== 1'b1 || bus_a.frame_err !== 1'b0 || bus_a.byte_cnt !== 8'd1) begin
            nerr++;
            $display("FAIL abort_recover got data=%h v=%b ferr=%b cnt=%0d want 5a 1 0 1",
                     bus_a.rx_data, bus_a.rx_valid, bus_a.frame_err, bus_a.byte_cnt);
        end
    endtask

    task automatic test_mid_reset();
        cs_start();
        spi_bits(8'hF0, 4);
        rst       = 1'b0;
        bus_a.cs  = 1'b1;
        wait_neg(3);
        nvec++;
        if (bus_a.rx_valid !== 1'b0 || bus_a.busy !== 1'b0 || bus_a.byte_cnt !== 8'd0) begin
            nerr++;
            $display("FAIL midreset_state got v=%b busy=%b cnt=%0d want 0 0 0",
                     bus_a.rx_valid, bus_a.busy, bus_a.byte_cnt);
        end
        rst = 1'b1;
        wait_neg(4);
        cs_start();
        spi_bits(8'hC3, 8);
        cs_end();
        nvec++;
        if (bus_a.rx_data !== 8'hC3 || bus_a.rx_valid !== 1'b1 || bus_a.frame_err !== 1'b0 || bus_a.byte_cnt !== 8'd1) begin
            nerr++;
            $display("FAIL midreset_word got data=%h v=%b ferr=%b cnt=%0d want c3 1 0 1",
                     bus_a.rx_data, bus_a.rx_valid, bus_a.frame_err, bus_a.byte_cnt);
        end
    endtask

    // Random frames with a fixed rx_ready policy, compared to a word-level model
    task automatic test_random();
        for (int f = 0; f < 6; f++) begin
            int         n;
            logic       rdy;
            logic       m_valid;
            logic       m_ovr;
            logic [7:0] m_data;
            logic [7:0] w;
            n   = int'($urandom_range(1, 4));
            rdy = 1'($urandom_range(0, 1));
            drain_a();
            pulse_clr_a();
            exp_q.delete();
            m_valid = 1'b0;
            m_ovr   = 1'b0;
            m_data  = 8'h00;
            bus_a.rx_ready = rdy;
            cs_start();
            for (int k = 0; k < n; k++) begin
                w = 8'($urandom);
                spi_bits(w, 8);
                if (m_valid && !rdy) begin
                    m_ovr = 1'b1;
                end else begin
                    m_data  = w;
                    m_valid = 1'b1;
                end
                if (rdy) begin
                    exp_q.push_back(m_data);
                    m_valid = 1'b0;
                end
            end
            cs_end();
            nvec++;
            if (xfers != exp_q || bus_a.rx_valid !== m_valid || bus_a.overrun !== m_ovr
                || bus_a.byte_cnt !== 8'(n) || (m_valid && bus_a.rx_data !== m_data)) begin
                nerr++;
                $display("FAIL random_frame%0d got xf=%0d v=%b ovr=%b cnt=%0d data=%h want xf=%0d v=%b ovr=%b cnt=%0d data=%h",
                         f, xfers.size(), bus_a.rx_valid, bus_a.overrun, bus_a.byte_cnt, bus_a.rx_data,
                         exp_q.size(), m_valid, m_ovr, n, m_data);
            end
            bus_a.rx_ready = 1'b0;
        end
    endtask

    task automatic test_saturation();
        logic [7:0] last;
        drain_a();
        bus_a.rx_ready = 1'b1;
        last = 8'h00;
        cs_start();
        for (int k = 0; k < 257; k++) begin
            last = 8'($urandom);
            spi_bits(last, 8);
        end
        cs_end();
        nvec++;
        if (bus_a.byte_cnt !== 8'd255) begin
            nerr++;
            $display("FAIL cnt_saturate got cnt=%0d want 255", bus_a.byte_cnt);
        end
        nvec++;
        if (xfers.size() != 257 || xfers[$] !== last) begin
            nerr++;
            $display("FAIL saturate_xfers got %0d want 257 last=%h", xfers.size(), last);
        end
        bus_a.rx_ready = 1'b0;
    endtask

    // Instance b: mosi changes with sclk rising, sampled on falling
    task automatic send_b(input logic [7:0] v);
        bus_b.rx_ready = 1'b1;
        wait_neg(2);
        bus_b.rx_ready = 1'b0;
        bus_b.cs = 1'b0;
        wait_neg(HALF);
        for (int i = 0; i < 8; i++) begin
            bus_b.sclk = 1'b1;
            bus_b.mosi = v[7-i];
            wait_neg(HALF);
            bus_b.sclk = 1'b0;
            wait_neg(HALF);
        end
        wait_neg(HALF);
        bus_b.cs = 1'b1;
        wait_neg(6);
    endtask

    task automatic test_sample_fall();
        logic [7:0] w;
        send_b(8'h81);
        nvec++;
        if (bus_b.rx_data !== 8'h81 || bus_b.rx_valid !== 1'b1 || bus_b.byte_cnt !== 8'd1) begin
            nerr++;
            $display("FAIL fall_81 got data=%h v=%b cnt=%0d want 81 1 1", bus_b.rx_data, bus_b.rx_valid, bus_b.byte_cnt);
        end
        w = 8'($urandom);
        send_b(w);
        nvec++;
        if (bus_b.rx_data !== w || bus_b.overrun !== 1'b0) begin
            nerr++;
            $display("FAIL fall_random got data=%h ovr=%b want %h 0", bus_b.rx_data, bus_b.overrun, w);
        end
    endtask

    initial begin
        nvec = 0;
        nerr = 0;
        rst  = 1'b0;
        bus_a.cs = 1'b1;  bus_a.sclk = 1'b0;  bus_a.mosi = 1'b0;
        bus_a.rx_ready = 1'b0;  bus_a.clr_err = 1'b0;
        bus_b.cs = 1'b1;  bus_b.sclk = 1'b0;  bus_b.mosi = 1'b0;
        bus_b.rx_ready = 1'b0;  bus_b.clr_err = 1'b0;
        wait_neg(2);
        test_reset();
        test_back_to_back();
        test_overrun();
        test_abort();
        test_mid_reset();
        test_random();
        test_saturation();
        test_sample_fall();
        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end
endmodule
